pc_fetch_gen: RTL and testbench

//   Next-generation program-counter generator for the fetch stage. Holds the PC, offers it to
//   the IFU over a valid/ready handshake, and advances sequentially or via a direct-mapped BTB

---
 rtl/pc_fetch_gen.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_gen
//  Brief    : Fetch-stage program-counter generator. Offers the PC to the
//             IFU over valid/ready, advances sequentially or through a
//             direct-mapped BTB with 2-bit counters, and accepts trap,
//             mispredict and halt control from the back end.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_gen #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 'h2000_0000,
    parameter int                    INST_BYTES  = 4,
    parameter int                    BTB_ENTRIES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic                  out_pred_taken,
    input  logic                  redir_valid,
    input  logic [DATA_WIDTH-1:0] redir_pc,
    input  logic                  trap_valid,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_taken,
    input  logic                  halt
);

    localparam int c_OFF_W = $clog2(INST_BYTES);
    localparam int c_IDX_W = $clog2(BTB_ENTRIES);
    localparam int c_TAG_W = DATA_WIDTH - c_OFF_W - c_IDX_W;
    localparam logic [DATA_WIDTH-1:0] c_INC = DATA_WIDTH'(INST_BYTES);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_nxt;

    // BTB storage; only the valid bits need a reset value
    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [c_TAG_W-1:0]     r_btb_tag    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  r_btb_target [BTB_ENTRIES];
    logic [1:0]             r_btb_ctr    [BTB_ENTRIES];

    logic [c_IDX_W-1:0] w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic               w_lk_hit;
    logic [c_IDX_W-1:0] w_upd_idx;
    logic [c_TAG_W-1:0] w_upd_tag;
    logic               w_upd_hit;
    logic               w_run;

    // Lookup uses the current PC; the offset bits never select an entry
    assign w_lk_idx  = r_pc[c_OFF_W +: c_IDX_W];
    assign w_lk_tag  = r_pc[DATA_WIDTH-1 -: c_TAG_W];
    assign w_lk_hit  = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_upd_idx = upd_pc[c_OFF_W +: c_IDX_W];
    assign w_upd_tag = upd_pc[DATA_WIDTH-1 -: c_TAG_W];
    assign w_upd_hit = r_btb_valid[w_upd_idx] && (r_btb_tag[w_upd_idx] == w_upd_tag);

    assign w_run          = (r_state == ST_RUN);
    assign out_valid      = w_run;
    assign out_pc         = r_pc;
    assign out_pred_taken = w_run && w_lk_hit && r_btb_ctr[w_lk_idx][1];

    // Instruction-offset bits of the update PC carry no BTB information
    generate
        if (c_OFF_W > 0) begin : g_off_sink
            logic w_unused_upd_off;
            assign w_unused_upd_off = ^upd_pc[c_OFF_W-1:0];
        end
    endgenerate

    // State and PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state / next PC: trap beats redirect beats halt beats advance
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (trap_valid) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = trap_pc;
        end else if (redir_valid) begin
            w_state_nxt = ST_RUN;
            w_pc_nxt    = redir_pc;
        end else begin
            case (r_state)
                ST_BOOT: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (halt) begin
                        w_state_nxt = ST_HALT;
                    end else if (out_ready) begin
                        w_pc_nxt = out_pred_taken ? r_btb_target[w_lk_idx] : r_pc + c_INC;
                    end
                end
                ST_HALT: w_state_nxt = ST_HALT;
                default: w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // BTB training: counters saturate, taken misses allocate weakly-taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btb_valid <= '0;
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                if (upd_taken) begin
                    r_btb_target[w_upd_idx] <= upd_target;
                    if (r_btb_ctr[w_upd_idx] != 2'b11) begin
                        r_btb_ctr[w_upd_idx] <= r_btb_ctr[w_upd_idx] + 2'b01;
                    end
                end else if (r_btb_ctr[w_upd_idx] != 2'b00) begin
                    r_btb_ctr[w_upd_idx] <= r_btb_ctr[w_upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                r_btb_valid[w_upd_idx]  <= 1'b1;
                r_btb_tag[w_upd_idx]    <= w_upd_tag;
                r_btb_target[w_upd_idx] <= upd_target;
                r_btb_ctr[w_upd_idx]    <= 2'b10;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pc_fetch_gen
//  Brief    : Directed self-checking bench for pc_fetch_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        halt;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_gen #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h2000_0000),
        .INST_BYTES (4),
        .BTB_ENTRIES(4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_pred_taken(out_pred_taken),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .halt          (halt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
        trap_valid = 1'b0; trap_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_target = '0; upd_taken = 1'b0; halt = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_pc} !== {1'b0, 32'h2000_0000}) begin
            n_errors++; $display("FAIL reset_c1: valid/pc=%b/%h want 0/20000000", out_valid, out_pc);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_pc, out_pred_taken} !== {1'b0, 32'h2000_0000, 1'b0}) begin
            n_errors++; $display("FAIL reset_c2: valid/pc/pt=%b/%h/%b want 0/20000000/0", out_valid, out_pc, out_pred_taken);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL boot_cycle: valid=%b want 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h2000_0000}) begin
            n_errors++; $display("FAIL first_fetch: valid/pc=%b/%h want 1/20000000", out_valid, out_pc);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h2000_0004}) begin
            n_errors++; $display("FAIL seq_1: valid/pc=%b/%h want 1/20000004", out_valid, out_pc);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h2000_0008}) begin
            n_errors++; $display("FAIL seq_2: valid/pc=%b/%h want 1/20000008", out_valid, out_pc);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_pc, out_pred_taken} !== {1'b1, 32'h2000_0008, 1'b0}) begin
                n_errors++; $display("FAIL stall_%0d: valid/pc/pt=%b/%h/%b want 1/20000008/0", i, out_valid, out_pc, out_pred_taken);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h2000_000C}) begin
            n_errors++; $display("FAIL stall_resume: valid/pc=%b/%h want 1/2000000c", out_valid, out_pc);
        end
    endtask

    task automatic test_btb();
        // Train a taken branch while the PC is still one slot ahead of it
        upd_valid = 1'b1; upd_pc = 32'h2000_0010; upd_target = 32'h2000_0100; upd_taken = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        n_checks++;
        if ({out_pc, out_pred_taken} !== {32'h2000_0010, 1'b1}) begin
            n_errors++; $display("FAIL btb_alloc: pc/pt=%h/%b want 20000010/1", out_pc, out_pred_taken);
        end
        @(negedge clk);
        n_checks++;
        if ({out_pc, out_pred_taken} !== {32'h2000_0100, 1'b0}) begin
            n_errors++; $display("FAIL btb_follow: pc/pt=%h/%b want 20000100/0", out_pc, out_pred_taken);
        end
        // Two not-taken updates: 10 -> 01 -> 00, then revisit the branch
        out_ready = 1'b0; upd_valid = 1'b1; upd_taken = 1'b0;
        @(negedge clk);
        redir_valid = 1'b1; redir_pc = 32'h2000_0010;
        @(negedge clk);
        upd_valid = 1'b0; redir_valid = 1'b0;
        n_checks++;
        if ({out_pc, out_pred_taken} !== {32'h2000_0010, 1'b0}) begin
            n_errors++; $display("FAIL btb_weakened: pc/pt=%h/%b want 20000010/0", out_pc, out_pred_taken);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_pc !== 32'h2000_0014) begin
            n_errors++; $display("FAIL btb_fallthru: pc=%h want 20000014", out_pc);
        end
        // Third not-taken must stay at 00: one taken step must then leave it at 01
        out_ready = 1'b0; upd_valid = 1'b1; upd_taken = 1'b0;
        @(negedge clk);
        upd_taken = 1'b1; redir_valid = 1'b1; redir_pc = 32'h2000_0010;
        @(negedge clk);
        redir_valid = 1'b0;
        n_checks++;
        if ({out_pc, out_pred_taken} !== {32'h2000_0010, 1'b0}) begin
            n_errors++; $display("FAIL btb_saturate_low: pc/pt=%h/%b want 20000010/0", out_pc, out_pred_taken);
        end
        // Second taken step (01 -> 10); lookup this cycle still sees 01
        @(negedge clk);
        upd_valid = 1'b0;
        n_checks++;
        if ({out_pc, out_pred_taken} !== {32'h2000_0010, 1'b1}) begin
            n_errors++; $display("FAIL btb_retrain: pc/pt=%h/%b want 20000010/1", out_pc, out_pred_taken);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_pc !== 32'h2000_0100) begin
            n_errors++; $display("FAIL btb_retrain_follow: pc=%h want 20000100", out_pc);
        end
    endtask

    task automatic test_priority();
        trap_valid = 1'b1; trap_pc = 32'h8000_0000;
        redir_valid = 1'b1; redir_pc = 32'h1234_0000; out_ready = 1'b1;
        @(negedge clk);
        trap_valid = 1'b0; redir_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h8000_0000}) begin
            n_errors++; $display("FAIL trap_over_redir: valid/pc=%b/%h want 1/80000000", out_valid, out_pc);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({out_valid, out_pc, out_pred_taken} !== {1'b0, 32'h8000_0000, 1'b0}) begin
                n_errors++; $display("FAIL halt_hold_%0d: valid/pc/pt=%b/%h/%b want 0/80000000/0", i, out_valid, out_pc, out_pred_taken);
            end
            @(negedge clk);
        end
        redir_valid = 1'b1; redir_pc = 32'h2000_0200;
        @(negedge clk);
        redir_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h2000_0200}) begin
            n_errors++; $display("FAIL halt_exit: valid/pc=%b/%h want 1/20000200", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC; out_ready = 1'b1;
        @(negedge clk);
        redir_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_errors++; $display("FAIL wrap_redir: valid/pc=%b/%h want 1/fffffffc", out_valid, out_pc);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h0000_0000}) begin
            n_errors++; $display("FAIL wrap_zero: valid/pc=%b/%h want 1/00000000", out_valid, out_pc);
        end
    endtask

    task automatic test_rst_in_halt();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL halt_again: valid=%b want 0", out_valid);
        end
        // Reset with a taken update pending for 2000_0020; it must be dropped
        rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h2000_0020;
        upd_target = 32'h2000_0300; upd_taken = 1'b1;
        @(negedge clk);
        rst = 1'b0; upd_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_pc} !== {1'b0, 32'h2000_0000}) begin
            n_errors++; $display("FAIL rst_halt: valid/pc=%b/%h want 0/20000000", out_valid, out_pc);
        end
        @(negedge clk);
        redir_valid = 1'b1; redir_pc = 32'h2000_0010;
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h2000_0000}) begin
            n_errors++; $display("FAIL rst_boot_run: valid/pc=%b/%h want 1/20000000", out_valid, out_pc);
        end
        @(negedge clk);
        redir_valid = 1'b0;
        n_checks++;
        if ({out_pc, out_pred_taken} !== {32'h2000_0010, 1'b0}) begin
            n_errors++; $display("FAIL rst_btb_clear: pc/pt=%h/%b want 20000010/0", out_pc, out_pred_taken);
        end
        @(negedge clk);
        n_checks++;
        if (out_pc !== 32'h2000_0014) begin
            n_errors++; $display("FAIL rst_btb_seq: pc=%h want 20000014", out_pc);
        end
        redir_valid = 1'b1; redir_pc = 32'h2000_0020;
        @(negedge clk);
        redir_valid = 1'b0;
        n_checks++;
        if ({out_pc, out_pred_taken} !== {32'h2000_0020, 1'b0}) begin
            n_errors++; $display("FAIL rst_drop_upd: pc/pt=%h/%b want 20000020/0", out_pc, out_pred_taken);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_btb();
        test_priority();
        test_halt();
        test_wrap();
        test_rst_in_halt();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
